// File: rtl/isp_ol_walker_if.sv
// VRAM read port and primitive-descriptor handshake between the object-list
// walker (master) and its VRAM/parser neighbours (slave).
interface isp_ol_walker_if #(
    parameter int ADDR_W = 24
);
    logic              ol_vram_rd;
    logic [ADDR_W-1:0] ol_vram_addr;
    logic [31:0]       ol_vram_din;

    logic              prim_valid;
    logic              prim_ready;
    logic [ADDR_W-1:0] prim_addr;
    logic [1:0]        prim_type;
    logic [5:0]        prim_mask;
    logic [2:0]        prim_skip;
    logic              prim_shadow;

    modport master (
        output ol_vram_rd, ol_vram_addr,
        input  ol_vram_din,
        output prim_valid, prim_addr, prim_type, prim_mask, prim_skip, prim_shadow,
        input  prim_ready
    );

    modport slave (
        input  ol_vram_rd, ol_vram_addr,
        output ol_vram_din,
        input  prim_valid, prim_addr, prim_type, prim_mask, prim_skip, prim_shadow,
        output prim_ready
    );
endinterface

// File: rtl/isp_ol_walker.sv
// Walks a PowerVR2 tile object list in VRAM and emits one descriptor per strip,
// array triangle or array quad for the downstream ISP parser.
module isp_ol_walker #(
    parameter int ADDR_W = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] ol_base,
    input  logic [ADDR_W-1:0] param_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    isp_ol_walker_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EMIT, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_STRIP, K_ARRAY, K_LINK, K_RESERVED
    } kind_t;

    localparam logic [1:0] T_STRIP = 2'd0;
    localparam logic [1:0] T_TRI   = 2'd1;
    localparam logic [1:0] T_QUAD  = 2'd2;

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        stride_q;
    logic [4:0]        count_q;
    logic [1:0]        type_q;
    logic [5:0]        mask_q;
    logic [2:0]        skip_q;
    logic              shadow_q;
    logic              err_flag;

    logic [31:0]       w;
    kind_t             d_kind;
    logic [4:0]        d_count;
    logic [3:0]        d_vwords;
    logic [7:0]        d_stride;
    logic [ADDR_W-1:0] d_addr;
    logic [ADDR_W-1:0] d_link;

    assign w = bus.ol_vram_din;

    // Classification of the word returned for the current FETCH.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        d_kind = K_STRIP;
        if (w[31]) begin
            unique case (w[30:29])
                2'b00, 2'b01: d_kind = K_ARRAY;
                2'b11:        d_kind = K_LINK;
                default:      d_kind = K_RESERVED;
            endcase
        end
        d_count  = w[31] ? ({1'b0, w[28:25]} + 5'd1) : 5'd1;
        d_vwords = 4'd3 + {1'b0, w[23:21]};
        d_stride = w[29] ? (8'd12 + 8'd16 * {4'd0, d_vwords})
                         : (8'd12 + 8'd12 * {4'd0, d_vwords});
        d_addr   = param_base + ADDR_W'({w[20:0], 2'b00});
        d_link   = ADDR_W'(w[23:0] & 24'hFF_FFFC);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (start) state_n = S_FETCH;
            S_FETCH:  state_n = S_WAIT;
            S_WAIT:   state_n = S_DECODE;
            S_DECODE: begin
                unique case (d_kind)
                    K_STRIP:    state_n = (w[30:25] == 6'd0) ? S_FETCH : S_EMIT;
                    K_ARRAY:    state_n = S_EMIT;
                    K_LINK:     state_n = w[28] ? S_DONE : S_FETCH;
                    K_RESERVED: state_n = S_DONE;
                    default:    state_n = S_DONE;
                endcase
            end
            S_EMIT:   if (bus.prim_ready && count_q == 5'd1) state_n = S_FETCH;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy            = (state != S_IDLE);
        done            = (state == S_DONE);
        err             = (state == S_DONE) && err_flag;
        bus.prim_valid  = (state == S_EMIT);
        bus.prim_addr   = addr_q;
        bus.prim_type   = type_q;
        bus.prim_mask   = mask_q;
        bus.prim_skip   = skip_q;
        bus.prim_shadow = shadow_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr              <= '0;
            addr_q           <= '0;
            stride_q         <= '0;
            count_q          <= '0;
            type_q           <= '0;
            mask_q           <= '0;
            skip_q           <= '0;
            shadow_q         <= 1'b0;
            err_flag         <= 1'b0;
            bus.ol_vram_rd   <= 1'b0;
            bus.ol_vram_addr <= '0;
        end else begin
            bus.ol_vram_rd <= (state == S_FETCH);
            unique case (state)
                S_IDLE: if (start) begin
                    ptr      <= ol_base & ~ADDR_W'(3);
                    err_flag <= 1'b0;
                end
                S_FETCH: bus.ol_vram_addr <= ptr;
                S_DECODE: begin
                    addr_q   <= d_addr;
                    stride_q <= d_stride;
                    count_q  <= d_count;
                    skip_q   <= w[23:21];
                    shadow_q <= w[24];
                    mask_q   <= w[31] ? 6'h3F : w[30:25];
                    type_q   <= !w[31] ? T_STRIP : (w[29] ? T_QUAD : T_TRI);
                    unique case (d_kind)
                        K_STRIP:    if (w[30:25] == 6'd0) ptr <= ptr + ADDR_W'(4);
                        K_LINK:     if (!w[28]) ptr <= d_link;
                        K_RESERVED: err_flag <= 1'b1;
                        default:    ;
                    endcase
                end
                S_EMIT: if (bus.prim_ready) begin
                    count_q <= count_q - 5'd1;
                    addr_q  <= addr_q + ADDR_W'(stride_q);
                    if (count_q == 5'd1) ptr <= ptr + ADDR_W'(4);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_isp_ol_walker.sv
// Self-checking bench for isp_ol_walker: directed list scenarios plus random
// object lists compared against a list-walking reference model.
module tb_isp_ol_walker;

    localparam int ADDR_W = 24;

    typedef struct packed {
        logic [23:0] addr;
        logic [1:0]  typ;
        logic [5:0]  mask;
        logic [2:0]  skip;
        logic        shadow;
    } desc_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] ol_base = '0;
    logic [23:0] param_base = '0;
    logic        busy, done, err;

    isp_ol_walker_if #(.ADDR_W(ADDR_W)) bus ();

    isp_ol_walker #(.ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .ol_base    (ol_base),
        .param_base (param_base),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Sparse VRAM; unwritten words read as an end-of-list link.
    logic [31:0] vmem [int];

    function automatic logic [31:0] vram_word(input logic [23:0] a);
        int key = int'(a[23:2]);
        return vmem.exists(key) ? vmem[key] : 32'hF000_0000;
    endfunction

    task automatic put(input logic [23:0] a, input logic [31:0] d);
        vmem[int'(a[23:2])] = d;
    endtask

    always @(posedge clock)
        if (bus.ol_vram_rd) bus.ol_vram_din <= vram_word(bus.ol_vram_addr);

    // Observation, sampled on the falling edge.
    int          neg_cnt = 0, start_neg = -1, first_valid = -1;
    int          done_cnt = 0, err_cnt = 0, err_alone = 0, stable_viol = 0;
    desc_t       got_q[$];
    int          acc_q[$];
    logic [23:0] rd_q[$];
    int          rdc_q[$];
    desc_t       prev_d;
    bit          prev_hold = 1'b0;

    function automatic desc_t cur_desc();
        return {bus.prim_addr, bus.prim_type, bus.prim_mask, bus.prim_skip, bus.prim_shadow};
    endfunction

    always @(negedge clock) begin
        neg_cnt = neg_cnt + 1;
        if (start && !busy) start_neg = neg_cnt;
        if (bus.ol_vram_rd) begin
            rd_q.push_back(bus.ol_vram_addr);
            rdc_q.push_back(neg_cnt);
        end
        if (bus.prim_valid) begin
            if (first_valid < 0) first_valid = neg_cnt;
            if (prev_hold && cur_desc() !== prev_d) stable_viol = stable_viol + 1;
            if (bus.prim_ready) begin
                got_q.push_back(cur_desc());
                acc_q.push_back(neg_cnt);
            end
        end
        prev_hold = bus.prim_valid && !bus.prim_ready;
        prev_d    = cur_desc();
        if (done) done_cnt = done_cnt + 1;
        if (err) err_cnt = err_cnt + 1;
        if (err && !done) err_alone = err_alone + 1;
    end

    // Reference model: walk the list word by word and expand arrays into prims.
    desc_t       exp_q[$];
    logic [23:0] exp_rd[$];
    int          exp_err;

    task automatic model(input logic [23:0] base, input logic [23:0] pbase);
        logic [23:0] p;
        logic [31:0] wd;
        int          n, vw, per, stride;
        exp_q.delete();
        exp_rd.delete();
        exp_err = 0;
        p = base & 24'hFF_FFFC;
        for (int guard = 0; guard < 4096; guard++) begin
            wd = vram_word(p);
            exp_rd.push_back(p);
            if (!wd[31]) begin
                if (wd[30:25] != 6'd0)
                    exp_q.push_back({24'(int'(pbase) + int'(wd[20:0]) * 4), 2'd0,
                                     wd[30:25], wd[23:21], wd[24]});
                p = p + 24'd4;
            end else if (!wd[30]) begin
                n      = int'(wd[28:25]) + 1;
                vw     = 3 + int'(wd[23:21]);
                per    = wd[29] ? 4 : 3;
                stride = 4 * (3 + per * vw);
                for (int i = 0; i < n; i++)
                    exp_q.push_back({24'(int'(pbase) + int'(wd[20:0]) * 4 + i * stride),
                                     wd[29] ? 2'd2 : 2'd1, 6'h3F, wd[23:21], wd[24]});
                p = p + 24'd4;
            end else if (wd[29]) begin
                if (wd[28]) break;
                p = {wd[23:2], 2'b00};
            end else begin
                exp_err = 1;
                break;
            end
        end
    endtask

    task automatic clear_obs();
        got_q.delete(); acc_q.delete(); rd_q.delete(); rdc_q.delete();
        first_valid = -1; start_neg = -1;
        done_cnt = 0; err_cnt = 0; err_alone = 0; stable_viol = 0;
    endtask

    task automatic run_walk(input string name, input logic [23:0] base, input logic [23:0] pbase,
                            input int ready_pct, input int low_n, input bit noise);
        int low_cnt = 0;
        bit finished = 1'b0;
        clear_obs();
        ol_base = base;
        param_base = pbase;
        bus.prim_ready = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done_cnt > 0) begin
                finished = 1'b1;
                break;
            end
            if (bus.prim_valid && low_cnt < low_n) begin
                bus.prim_ready = 1'b0;
                low_cnt++;
            end else begin
                bus.prim_ready = ($urandom_range(0, 99) < ready_pct);
            end
            start   = noise && busy && ($urandom_range(0, 7) == 0);
            ol_base = noise ? 24'($urandom) : base;
            @(posedge clock); #1;
        end
        start = 1'b0;
        bus.prim_ready = 1'b0;
        check({name, ".finished"}, 64'(finished), 64'd1);
        if (!finished) begin
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
        end
        @(posedge clock); #1;
    endtask

    task automatic compare(input string name);
        check({name, ".n_prims"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s.prim%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
        check({name, ".n_reads"}, 64'(rd_q.size()), 64'(exp_rd.size()));
        for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
            check($sformatf("%s.rd%0d", name, i), 64'(rd_q[i]), 64'(exp_rd[i]));
        check({name, ".done_cnt"}, 64'(done_cnt), 64'd1);
        check({name, ".err_cnt"}, 64'(err_cnt), 64'(exp_err));
        check({name, ".err_alone"}, 64'(err_alone), 64'd0);
        check({name, ".stable"}, 64'(stable_viol), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] base, pbase, region;
        logic [31:0] ent;
        int          n_ent;

        bus.prim_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset.ctrl", 64'({bus.prim_valid, busy, done, err, bus.ol_vram_rd}), 64'd0);
        check("reset.addrs", 64'({bus.ol_vram_addr, bus.prim_addr}), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Single strip, then end link.
        vmem.delete();
        put(24'h001000, 32'h7E20_0100);
        put(24'h001004, 32'hF000_0000);
        model(24'h001000, 24'h010000);
        run_walk("strip", 24'h001000, 24'h010000, 100, 0, 1'b0);
        compare("strip");
        check("strip.desc", 64'(got_q.size() > 0 ? got_q[0] : '0),
              64'({24'h010400, 2'd0, 6'h3F, 3'd1, 1'b0}));
        check("strip.rd_time", 64'(rdc_q.size() > 0 ? rdc_q[0] - start_neg : -1), 64'd2);
        check("strip.valid_time", 64'(first_valid - start_neg), 64'd4);

        // Triangle array, three prims back to back.
        vmem.delete();
        put(24'h001000, 32'h8400_0040);
        put(24'h001004, 32'hF000_0000);
        model(24'h001000, 24'h010000);
        run_walk("tri", 24'h001000, 24'h010000, 100, 0, 1'b0);
        compare("tri");
        check("tri.addrs", 64'(got_q.size() == 3 ? {got_q[0].addr, got_q[1].addr, got_q[2].addr} : '0),
              64'({24'h010100, 24'h010130}) << 24 | 64'h010160);
        check("tri.gap01", 64'(acc_q.size() == 3 ? acc_q[1] - acc_q[0] : -1), 64'd1);
        check("tri.gap12", 64'(acc_q.size() == 3 ? acc_q[2] - acc_q[1] : -1), 64'd1);

        // Quad array held off for five cycles.
        vmem.delete();
        put(24'h001000, 32'hA040_0000);
        put(24'h001004, 32'hF000_0000);
        model(24'h001000, 24'h010000);
        run_walk("quad", 24'h001000, 24'h010000, 100, 5, 1'b0);
        compare("quad");
        check("quad.desc", 64'(got_q.size() > 0 ? got_q[0] : '0),
              64'({24'h010000, 2'd2, 6'h3F, 3'd2, 1'b0}));
        check("quad.accept_time", 64'(acc_q.size() > 0 ? acc_q[0] - first_valid : -1), 64'd5);
        check("quad.next_rd", 64'(rdc_q.size() > 1 && acc_q.size() > 0 ? rdc_q[1] - acc_q[0] : -1), 64'd2);

        // Empty strip skipped, then a block link.
        vmem.delete();
        put(24'h001000, 32'h0000_0010);
        put(24'h001004, 32'hE000_2000);
        put(24'h002000, 32'hF000_0000);
        model(24'h001000, 24'h010000);
        run_walk("link", 24'h001000, 24'h010000, 100, 0, 1'b0);
        compare("link");
        check("link.no_valid", 64'(first_valid), 64'(-1));
        check("link.rd_seq", 64'(rd_q.size() == 3 ? {rd_q[0], rd_q[1]} : '0), 64'({24'h001000, 24'h001004}));

        // Reserved entry type.
        vmem.delete();
        put(24'h001000, 32'hC000_0000);
        model(24'h001000, 24'h010000);
        run_walk("rsv", 24'h001000, 24'h010000, 100, 0, 1'b0);
        compare("rsv");
        check("rsv.err", 64'(err_cnt), 64'd1);

        // Start while busy is ignored; reset mid-EMIT clears everything.
        vmem.delete();
        put(24'h001000, 32'h8400_0040);
        clear_obs();
        ol_base = 24'h001000;
        param_base = 24'h010000;
        bus.prim_ready = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && !bus.prim_valid; c++) begin
            @(posedge clock); #1;
        end
        check("hold.valid_seen", 64'(bus.prim_valid), 64'd1);
        ol_base = 24'h002000;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("busy_start.reads", 64'(rd_q.size()), 64'd1);
        check("busy_start.addr", 64'(bus.prim_addr), 64'h010100);
        reset = 1'b1;
        start = 1'b1;
        bus.prim_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst_emit.ctrl", 64'({bus.prim_valid, busy, done, err, bus.ol_vram_rd}), 64'd0);
        check("rst_emit.addrs", 64'({bus.ol_vram_addr, bus.prim_addr}), 64'd0);
        check("rst_emit.fields", 64'({bus.prim_type, bus.prim_mask, bus.prim_skip, bus.prim_shadow}), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        start = 1'b0;
        bus.prim_ready = 1'b0;
        @(negedge clock);
        check("rst_emit.idle", 64'(busy), 64'd0);
        @(posedge clock); #1;

        // Random lists with random backpressure and start noise while busy.
        for (int t = 0; t < 25; t++) begin
            vmem.delete();
            base   = 24'($urandom_range(0, 255)) << 12;
            pbase  = 24'($urandom);
            region = base;
            n_ent  = $urandom_range(1, 6);
            for (int e = 0; e < n_ent; e++) begin
                ent = $urandom;
                case ($urandom_range(0, 3))
                    0: ent[31:25] = {1'b0, 6'd0};
                    1: ent[31]    = 1'b0;
                    2: ent[31:29] = 3'b100;
                    default: ent[31:29] = 3'b101;
                endcase
                put(region, ent);
                region = region + 24'd4;
                if (e == 1 && $urandom_range(0, 1) == 1) begin
                    put(region, {8'hE0, base + 24'h100000 + 24'h000800});
                    region = base + 24'h100000 + 24'h000800;
                end
            end
            put(region, ($urandom_range(0, 9) == 0) ? 32'hC000_0000 : 32'hF000_0000);
            model(base | 24'($urandom_range(0, 3)), pbase);
            run_walk($sformatf("rnd%0d", t), base | 24'($urandom_range(0, 3)) & 24'hFF_FFFF, pbase,
                     $urandom_range(30, 100), $urandom_range(0, 3), 1'b1);
            compare($sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
